// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_stage_reg: control-bundle bit layout, bubble IR and stage occupancy states.
package pipe_pkg;

    localparam int unsigned CTRL_W = 13;

    localparam int unsigned CTRL_REGDESTS    = 12;
    localparam int unsigned CTRL_REGWRITE    = 11;
    localparam int unsigned CTRL_ALUSRC      = 10;
    localparam int unsigned CTRL_MEMREAD     = 9;
    localparam int unsigned CTRL_MEMWRITE    = 8;
    localparam int unsigned CTRL_MEMTOREG    = 7;
    localparam int unsigned CTRL_BRANCHS     = 6;
    localparam int unsigned CTRL_JUMPS       = 5;
    localparam int unsigned CTRL_ALUCTRL_MSB = 4;
    localparam int unsigned CTRL_ALUCTRL_LSB = 1;

    localparam logic [31:0] NOP_IR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One field-bundle register of the stage; reset > load > bubble clear.
// Bubble clear zeroes ctrl/rd and sets IR to NOP_IR; B and result keep their last value.
module pipe_entry #(
    parameter int unsigned   DATA_W = 32,
    parameter int unsigned   CTRL_W = 13,
    parameter int unsigned   ADDR_W = 5,
    parameter int unsigned   IR_W   = 32,
    parameter logic [IR_W-1:0] NOP_IR = '0
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              ld_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [IR_W-1:0]   ir_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [ADDR_W-1:0] rd_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [IR_W-1:0]   ir_o,
    output logic [DATA_W-1:0] b_o,
    output logic [DATA_W-1:0] result_o,
    output logic [ADDR_W-1:0] rd_o
);
    import pipe_pkg::*;

    logic [CTRL_W-1:0] ctrl_q;
    logic [IR_W-1:0]   ir_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic [ADDR_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            ir_q     <= NOP_IR;
            b_q      <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else if (ld_i) begin
            ctrl_q   <= ctrl_i;
            ir_q     <= ir_i;
            b_q      <= b_i;
            result_q <= result_i;
            rd_q     <= rd_i;
        end else if (clr_i) begin
            ctrl_q <= '0;
            ir_q   <= NOP_IR;
            rd_q   <= '0;
        end
    end

    assign ctrl_o   = ctrl_q;
    assign ir_o     = ir_q;
    assign b_o      = b_q;
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, one-entry skid buffer, flush-to-bubble.
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_stage_reg #(
    parameter int unsigned     DATA_W = 32,
    parameter int unsigned     CTRL_W = pipe_pkg::CTRL_W,
    parameter int unsigned     ADDR_W = 5,
    parameter int unsigned     IR_W   = 32,
    parameter logic [IR_W-1:0] NOP_IR = IR_W'(pipe_pkg::NOP_IR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_result,
    input  logic [ADDR_W-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [IR_W-1:0]   out_ir,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_result,
    output logic [ADDR_W-1:0] out_rd
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);
    import pipe_pkg::*;

    pipe_state_e state_q, state_d;

    logic main_v, skid_v;
    logic in_fire, out_fire;
    logic main_ld, main_from_skid, main_clr, skid_ld;

    logic [CTRL_W-1:0] skid_ctrl, main_ctrl_d;
    logic [IR_W-1:0]   skid_ir, main_ir_d;
    logic [DATA_W-1:0] skid_b, main_b_d;
    logic [DATA_W-1:0] skid_result, main_result_d;
    logic [ADDR_W-1:0] skid_rd, main_rd_d;

    assign main_v    = (state_q != ST_EMPTY);
    assign skid_v    = (state_q == ST_FULL);
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_ld = 1'b1;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    skid_ld = 1'b1;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ST_HALF;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any load, including a same-cycle in_fire.
        if (flush) begin
            state_d = ST_EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    // Clearing main whenever it will be empty keeps the bubble outputs purely registered.
    assign main_clr = (state_d == ST_EMPTY);

    always_comb begin
        main_ctrl_d   = in_ctrl;
        main_ir_d     = in_ir;
        main_b_d      = in_b;
        main_result_d = in_result;
        main_rd_d     = in_rd;
        if (main_from_skid) begin
            main_ctrl_d   = skid_ctrl;
            main_ir_d     = skid_ir;
            main_b_d      = skid_b;
            main_result_d = skid_result;
            main_rd_d     = skid_rd;
        end
    end

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .ADDR_W (ADDR_W),
        .IR_W   (IR_W),
        .NOP_IR (NOP_IR)
    ) u_main (
        .clk      (clk),
        .rst_i    (reset),
        .ld_i     (main_ld),
        .clr_i    (main_clr),
        .ctrl_i   (main_ctrl_d),
        .ir_i     (main_ir_d),
        .b_i      (main_b_d),
        .result_i (main_result_d),
        .rd_i     (main_rd_d),
        .ctrl_o   (out_ctrl),
        .ir_o     (out_ir),
        .b_o      (out_b),
        .result_o (out_result),
        .rd_o     (out_rd)
    );

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .ADDR_W (ADDR_W),
        .IR_W   (IR_W),
        .NOP_IR (NOP_IR)
    ) u_skid (
        .clk      (clk),
        .rst_i    (reset),
        .ld_i     (skid_ld),
        .clr_i    (flush),
        .ctrl_i   (in_ctrl),
        .ir_i     (in_ir),
        .b_i      (in_b),
        .result_i (in_result),
        .rd_i     (in_rd),
        .ctrl_o   (skid_ctrl),
        .ir_o     (skid_ir),
        .b_o      (skid_b),
        .result_o (skid_result),
        .rd_o     (skid_rd)
    );

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    // skid_v implies main_v, so main_v alone means "occupied".
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_v && !out_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush && main_v && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; occupancy/order model is a FIFO of depth 2.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 13;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned IR_W   = 32;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [IR_W-1:0]   in_ir = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic [DATA_W-1:0] in_result = '0;
    logic [ADDR_W-1:0] in_rd = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CTRL_W-1:0] out_ctrl;
    logic [IR_W-1:0]   out_ir;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_result;
    logic [ADDR_W-1:0] out_rd;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .ADDR_W (ADDR_W),
        .IR_W   (IR_W),
        .NOP_IR (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_ir      (in_ir),
        .in_b       (in_b),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_ir     (out_ir),
        .out_b      (out_b),
        .out_result (out_result),
        .out_rd     (out_rd)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] res;
        logic [ADDR_W-1:0] rd;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_rst_vals = 1'b0;
    logic [15:0] exp_stall = '0;
    logic [15:0] exp_flush = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ir, input logic [4:0] rd);
        in_valid  = v;
        in_ir     = ir;
        in_rd     = rd;
        in_ctrl   = CTRL_W'($urandom);
        in_b      = $urandom;
        in_result = $urandom;
    endtask

    // Check outputs against the model, advance the model, then move to the next negedge.
    task automatic step();
        bit   mready;
        ent_t e;
        mready = (q.size() < 2);
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(mready));
        if (q.size() != 0) begin
            check("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
            check("out_ir", out_ir, q[0].ir);
            check("out_b", out_b, q[0].b);
            check("out_result", out_result, q[0].res);
            check("out_rd", 32'(out_rd), 32'(q[0].rd));
        end else begin
            check("bubble_ctrl", 32'(out_ctrl), 32'd0);
            check("bubble_ir", out_ir, NOP);
            check("bubble_rd", 32'(out_rd), 32'd0);
        end
        if (chk_rst_vals) begin
            check("rst_b", out_b, 32'd0);
            check("rst_result", out_result, 32'd0);
            chk_rst_vals = 1'b0;
        end
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(exp_flush));
`endif
        if (reset) begin
            q.delete();
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (q.size() != 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
            if (q.size() != 0 && flush && exp_flush != 16'hFFFF) exp_flush++;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && mready) begin
                    e.ctrl = in_ctrl; e.ir = in_ir; e.b = in_b; e.res = in_result; e.rd = in_rd;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        step();
        reset = 1'b0;
        chk_rst_vals = 1'b1;
    endtask

    initial begin
        // Initial reset: DUT state is unknown before the first edge, so no checks yet.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_rst_vals = 1'b1;

        // Single push, 1-cycle latency, then bubble.
        out_ready = 1'b1;
        drive(1'b1, 32'h0123_4567, 5'd9);
        step();
        drive(1'b0, 32'h0, 5'd0);
        step();
        step();
        check("single_ir_gone", out_ir, NOP);

        // Back-to-back stream IR 1..8.
        for (int unsigned i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 5'(i));
            step();
        end
        drive(1'b0, 32'h0, 5'd0);
        repeat (2) step();

        // Downstream stall: A, B fill the stage; C offered while full is refused.
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 5'd1); step();
        drive(1'b1, 32'hBBBB_0002, 5'd2); step();
        drive(1'b1, 32'hCCCC_0003, 5'd3); step();
        check("stall_full_ir", out_ir, 32'hAAAA_0001);
        step();
        drive(1'b0, 32'h0, 5'd0);
        out_ready = 1'b1;
        repeat (3) step();

        // Flush in FULL with a simultaneous push.
        out_ready = 1'b0;
        drive(1'b1, 32'h1111_0001, 5'd4); step();
        drive(1'b1, 32'h2222_0002, 5'd5); step();
        flush = 1'b1;
        drive(1'b1, 32'h3333_000C, 5'd6); step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0);
        out_ready = 1'b1;
        check("flush_bubble_ir", out_ir, NOP);
        repeat (2) step();

        // Reset while FULL and stalled, then a push with 1-cycle latency.
        out_ready = 1'b0;
        drive(1'b1, 32'h4444_0001, 5'd7); step();
        drive(1'b1, 32'h5555_0002, 5'd8); step();
        flush = 1'b1;
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h6666_0003, 5'd10); step();
        drive(1'b0, 32'h0, 5'd0); step();
        step();

        // Random traffic with occasional flushes.
        for (int unsigned i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0);
        out_ready = 1'b1;
        repeat (3) step();

`ifdef PIPE_STAGE_PERF_EN
        // Counter saturation and flush counting.
        do_reset();
        drive(1'b1, 32'h7777_0001, 5'd11); step();
        drive(1'b0, 32'h0, 5'd0);
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 70000; i++) step();
        check("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
        for (int unsigned k = 0; k < 3; k++) begin
            drive(1'b1, 32'(k + 100), 5'(k)); step();
            drive(1'b0, 32'h0, 5'd0);
            flush = 1'b1; step();
            flush = 1'b0;
        end
        step();
        check("flush_cnt3", 32'(flush_cnt), 32'd3);
        out_ready = 1'b1;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
